// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and pipe_hazard_ctrl.
// The datapath (master) presents per-stage register numbers and write flags
// and receives stall/flush/forward controls from the controller (slave).
interface pipe_hazard_ctrl_if;
    // D stage
    logic [4:0] rs_d;
    logic [4:0] rt_d;
    logic       branch_d;
    logic       pc_src_d;
    // E stage
    logic [4:0] rs_e;
    logic [4:0] rt_e;
    logic [4:0] wa_e;
    logic       we_e;
    logic       memtoreg_e;
    logic       mc_start_e;
    // M / W stages
    logic [4:0] wa_m;
    logic       we_m;
    logic       memtoreg_m;
    logic [4:0] wa_w;
    logic       we_w;
    // controls back to the datapath
    logic       stall_f;
    logic       stall_d;
    logic       stall_e;
    logic       flush_d;
    logic       flush_e;
    logic       flush_m;
    logic [1:0] fwd_a_e;
    logic [1:0] fwd_b_e;
    logic       fwd_a_d;
    logic       fwd_b_d;
    logic       mc_busy;
    logic       mc_done;

    modport master (
        output rs_d, rt_d, branch_d, pc_src_d,
        output rs_e, rt_e, wa_e, we_e, memtoreg_e, mc_start_e,
        output wa_m, we_m, memtoreg_m, wa_w, we_w,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
        input  fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, mc_busy, mc_done
    );

    modport slave (
        input  rs_d, rt_d, branch_d, pc_src_d,
        input  rs_e, rt_e, wa_e, we_e, memtoreg_e, mc_start_e,
        input  wa_m, we_m, memtoreg_m, wa_w, we_w,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
        output fwd_a_e, fwd_b_e, fwd_a_d, fwd_b_d, mc_busy, mc_done
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use / branch stalls,
// branch flush, E/D operand forwarding and a multi-cycle E-stage op
// (mult/div) that freezes F/D/E for MC_LAT cycles.
// Optional macro HAZ_FORWARD_EN enables forwarding; without it the forward
// selects stay 0 and any pending E/M write to a D source stalls instead.
module pipe_hazard_ctrl #(
    parameter int MC_LAT = 32
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic {RUN, MC_WAIT} state_t;

    localparam logic [7:0] MC_LOAD = 8'(MC_LAT - 2);

    state_t     state;
    logic [7:0] mc_cnt;
    logic       busy;
    logic       data_hazard;

    // Register 0 is hardwired to zero, so it never produces a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // Multi-cycle op sequencer: RUN launches, MC_WAIT counts down to completion.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= RUN;
            mc_cnt <= 8'd0;
        end else begin
            case (state)
                RUN: begin
                    if (hz.mc_start_e) begin
                        state  <= MC_WAIT;
                        mc_cnt <= MC_LOAD;
                    end
                end
                MC_WAIT: begin
                    if (mc_cnt == 8'd0) begin
                        state <= RUN;
                    end else begin
                        mc_cnt <= mc_cnt - 8'd1;
                    end
                end
                default: begin
                    state  <= RUN;
                    mc_cnt <= 8'd0;
                end
            endcase
        end
    end

    // Dependency detection between D sources and in-flight E/M writes.
    always_comb begin
        logic e_hits_d;
        logic m_hits_d;
        e_hits_d    = reg_match(hz.wa_e, hz.rs_d) | reg_match(hz.wa_e, hz.rt_d);
        m_hits_d    = reg_match(hz.wa_m, hz.rs_d) | reg_match(hz.wa_m, hz.rt_d);
        data_hazard = 1'b0;
`ifdef HAZ_FORWARD_EN
        // Only loads in E, or branches that compare in D before the value is ready, stall.
        data_hazard = (hz.memtoreg_e & hz.we_e & e_hits_d)
                    | (hz.branch_d & ((hz.we_e & e_hits_d) | (hz.memtoreg_m & m_hits_d)));
`else
        // No bypass paths: any pending E or M write to a D source must drain first.
        data_hazard = (hz.we_e & e_hits_d) | (hz.we_m & m_hits_d);
`endif
    end

    // Stall/flush arbitration: multi-cycle op beats data hazards beats branch flush.
    always_comb begin
        busy       = (state == MC_WAIT) | ((state == RUN) & hz.mc_start_e);
        hz.mc_busy = busy;
        hz.mc_done = (state == MC_WAIT) & (mc_cnt == 8'd0);
        hz.stall_f = busy | data_hazard;
        hz.stall_d = busy | data_hazard;
        hz.stall_e = busy;
        hz.flush_m = busy;
        hz.flush_e = ~busy & data_hazard;
        hz.flush_d = hz.pc_src_d & ~(busy | data_hazard);
    end

    // Operand bypass selects; the younger M result takes precedence over W.
    always_comb begin
        hz.fwd_a_e = 2'b00;
        hz.fwd_b_e = 2'b00;
        hz.fwd_a_d = 1'b0;
        hz.fwd_b_d = 1'b0;
`ifdef HAZ_FORWARD_EN
        if (hz.we_m & reg_match(hz.wa_m, hz.rs_e)) begin
            hz.fwd_a_e = 2'b10;
        end else if (hz.we_w & reg_match(hz.wa_w, hz.rs_e)) begin
            hz.fwd_a_e = 2'b01;
        end
        if (hz.we_m & reg_match(hz.wa_m, hz.rt_e)) begin
            hz.fwd_b_e = 2'b10;
        end else if (hz.we_w & reg_match(hz.wa_w, hz.rt_e)) begin
            hz.fwd_b_e = 2'b01;
        end
        hz.fwd_a_d = hz.we_m & reg_match(hz.wa_m, hz.rs_d);
        hz.fwd_b_d = hz.we_m & reg_match(hz.wa_m, hz.rt_d);
`endif
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl (MC_LAT=4): directed vector table,
// hand-written multi-cycle and reset sequences, then random stimulus against
// a rule-level reference model. Honours HAZ_FORWARD_EN like the design.
module tb_pipe_hazard_ctrl;

    localparam int MC_LAT = 4;
`ifdef HAZ_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [4:0] rs_d;
        logic [4:0] rt_d;
        logic       branch_d;
        logic       pc_src_d;
        logic [4:0] rs_e;
        logic [4:0] rt_e;
        logic [4:0] wa_e;
        logic       we_e;
        logic       memtoreg_e;
        logic       mc_start_e;
        logic [4:0] wa_m;
        logic       we_m;
        logic       memtoreg_m;
        logic [4:0] wa_w;
        logic       we_w;
    } stim_t;

    typedef struct packed {
        stim_t      s;
        logic       stall;
        logic       flush_e;
        logic       flush_d;
        logic [1:0] fa_e;
        logic [1:0] fb_e;
        logic       fa_d;
        logic       fb_d;
    } vec_t;

    logic  clk;
    logic  rst;
    int    total;
    int    bad;
    int    busy_left;
    stim_t cur;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl #(.MC_LAT(MC_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input stim_t s);
        cur            = s;
        hif.rs_d       = s.rs_d;
        hif.rt_d       = s.rt_d;
        hif.branch_d   = s.branch_d;
        hif.pc_src_d   = s.pc_src_d;
        hif.rs_e       = s.rs_e;
        hif.rt_e       = s.rt_e;
        hif.wa_e       = s.wa_e;
        hif.we_e       = s.we_e;
        hif.memtoreg_e = s.memtoreg_e;
        hif.mc_start_e = s.mc_start_e;
        hif.wa_m       = s.wa_m;
        hif.we_m       = s.we_m;
        hif.memtoreg_m = s.memtoreg_m;
        hif.wa_w       = s.wa_w;
        hif.we_w       = s.we_w;
    endtask

    task automatic checkOutput(input string name, input logic [1:0] act, input logic [1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output against a full set of expected values.
    task automatic checkAll(input string tag, input logic stall, input logic busy, input logic done,
                            input logic flush_e, input logic flush_d,
                            input logic [1:0] fa_e, input logic [1:0] fb_e,
                            input logic fa_d, input logic fb_d);
        checkOutput({tag, ".stall_f"}, {1'b0, hif.stall_f}, {1'b0, stall});
        checkOutput({tag, ".stall_d"}, {1'b0, hif.stall_d}, {1'b0, stall});
        checkOutput({tag, ".stall_e"}, {1'b0, hif.stall_e}, {1'b0, busy});
        checkOutput({tag, ".flush_m"}, {1'b0, hif.flush_m}, {1'b0, busy});
        checkOutput({tag, ".flush_e"}, {1'b0, hif.flush_e}, {1'b0, flush_e});
        checkOutput({tag, ".flush_d"}, {1'b0, hif.flush_d}, {1'b0, flush_d});
        checkOutput({tag, ".mc_busy"}, {1'b0, hif.mc_busy}, {1'b0, busy});
        checkOutput({tag, ".mc_done"}, {1'b0, hif.mc_done}, {1'b0, done});
        checkOutput({tag, ".fwd_a_e"}, hif.fwd_a_e, fa_e);
        checkOutput({tag, ".fwd_b_e"}, hif.fwd_b_e, fb_e);
        checkOutput({tag, ".fwd_a_d"}, {1'b0, hif.fwd_a_d}, {1'b0, fa_d});
        checkOutput({tag, ".fwd_b_d"}, {1'b0, hif.fwd_b_d}, {1'b0, fb_d});
    endtask

    function automatic bit hit(input logic [4:0] a, input logic [4:0] b);
        return (a != 5'd0) && (a == b);
    endfunction

    // Reference model: outputs follow directly from the hazard rules plus the
    // number of multi-cycle wait cycles still outstanding.
    task automatic checkModel(input string tag);
        bit busy, done, dep_e, dep_m, hz, stall;
        logic [1:0] fa_e, fb_e;
        busy  = (busy_left > 0) || cur.mc_start_e;
        done  = (busy_left == 1);
        dep_e = hit(cur.wa_e, cur.rs_d) || hit(cur.wa_e, cur.rt_d);
        dep_m = hit(cur.wa_m, cur.rs_d) || hit(cur.wa_m, cur.rt_d);
        if (FWD)
            hz = (cur.memtoreg_e && cur.we_e && dep_e)
              || (cur.branch_d && ((cur.we_e && dep_e) || (cur.memtoreg_m && dep_m)));
        else
            hz = (cur.we_e && dep_e) || (cur.we_m && dep_m);
        stall = busy || hz;
        fa_e = 2'd0;
        fb_e = 2'd0;
        if (FWD) begin
            if (cur.we_m && hit(cur.wa_m, cur.rs_e)) fa_e = 2'd2;
            else if (cur.we_w && hit(cur.wa_w, cur.rs_e)) fa_e = 2'd1;
            if (cur.we_m && hit(cur.wa_m, cur.rt_e)) fb_e = 2'd2;
            else if (cur.we_w && hit(cur.wa_w, cur.rt_e)) fb_e = 2'd1;
        end
        checkAll(tag, stall, busy, done, !busy && hz, cur.pc_src_d && !stall, fa_e, fb_e,
                 FWD && cur.we_m && hit(cur.wa_m, cur.rs_d),
                 FWD && cur.we_m && hit(cur.wa_m, cur.rt_d));
    endtask

    // Step one clock and advance the model's outstanding-wait count.
    task automatic advance();
        @(posedge clk);
        if (!rst) busy_left = 0;
        else if (busy_left > 0) busy_left--;
        else if (cur.mc_start_e) busy_left = MC_LAT - 1;
        #1;
    endtask

    task automatic runCycle(input stim_t s, input string tag);
        applyStimulus(s);
        @(negedge clk);
        checkModel(tag);
        advance();
    endtask

    vec_t  tbl[$];
    vec_t  t;
    stim_t s;

    initial begin
        total     = 0;
        bad       = 0;
        busy_left = 0;
        rst       = 1'b0;
        applyStimulus('0);

        // Reset with idle inputs: everything low.
        #2;
        checkAll("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed combinational vectors (FSM idle in RUN).
        t = '0; t.s.memtoreg_e = 1; t.s.we_e = 1; t.s.wa_e = 5; t.s.rs_d = 5;
        t.stall = 1; t.flush_e = 1; tbl.push_back(t);
        t = '0; t.s.memtoreg_e = 1; t.s.we_e = 1; t.s.wa_e = 0; t.s.rs_d = 5;
        tbl.push_back(t);
        t = '0; t.s.we_m = 1; t.s.wa_m = 7; t.s.we_w = 1; t.s.wa_w = 7; t.s.rs_e = 7;
        t.fa_e = FWD ? 2'b10 : 2'b00; tbl.push_back(t);
        t = '0; t.s.we_m = 0; t.s.wa_m = 7; t.s.we_w = 1; t.s.wa_w = 7; t.s.rs_e = 7;
        t.fa_e = FWD ? 2'b01 : 2'b00; tbl.push_back(t);
        t = '0; t.s.branch_d = 1; t.s.pc_src_d = 1; t.flush_d = 1; tbl.push_back(t);
        t = '0; t.s.branch_d = 1; t.s.pc_src_d = 1; t.s.memtoreg_e = 1; t.s.we_e = 1;
        t.s.wa_e = 5; t.s.rt_d = 5; t.stall = 1; t.flush_e = 1; tbl.push_back(t);
        t = '0; t.s.we_m = 1; t.s.wa_m = 3; t.s.rt_d = 3; t.s.rt_e = 3;
        t.stall = !FWD; t.flush_e = !FWD; t.fb_e = FWD ? 2'b10 : 2'b00; t.fb_d = FWD;
        tbl.push_back(t);
        t = '0; t.s.branch_d = 1; t.s.we_e = 1; t.s.wa_e = 9; t.s.rs_d = 9;
        t.stall = 1; t.flush_e = 1; tbl.push_back(t);
        t = '0; t.s.we_e = 1; t.s.wa_e = 9; t.s.rs_d = 9;
        t.stall = !FWD; t.flush_e = !FWD; tbl.push_back(t);
        t = '0; t.s.branch_d = 1; t.s.memtoreg_m = 1; t.s.we_m = 1; t.s.wa_m = 4; t.s.rs_d = 4;
        t.stall = 1; t.flush_e = 1; t.fa_d = FWD; tbl.push_back(t);
        t = '0; t.s.we_w = 1; t.s.wa_w = 6; t.s.rt_e = 6;
        t.fb_e = FWD ? 2'b01 : 2'b00; tbl.push_back(t);
        t = '0; t.s.we_m = 1; t.s.we_e = 1; t.s.memtoreg_e = 1; t.s.we_w = 1;
        t.s.pc_src_d = 1; t.flush_d = 1; tbl.push_back(t);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].s);
            @(negedge clk);
            checkAll($sformatf("vec%0d", i), tbl[i].stall, 1'b0, 1'b0, tbl[i].flush_e,
                     tbl[i].flush_d, tbl[i].fa_e, tbl[i].fb_e, tbl[i].fa_d, tbl[i].fb_d);
            advance();
        end

        // Multi-cycle op: start pulse on cycle 0, busy through cycle 3, done on 3.
        for (int c = 0; c < 6; c++) begin
            s = '0;
            s.mc_start_e = (c == 0);
            s.pc_src_d   = 1'b1;
            applyStimulus(s);
            @(negedge clk);
            checkOutput($sformatf("mc%0d.mc_busy", c), {1'b0, hif.mc_busy}, {1'b0, c <= 3});
            checkOutput($sformatf("mc%0d.mc_done", c), {1'b0, hif.mc_done}, {1'b0, c == 3});
            checkOutput($sformatf("mc%0d.flush_m", c), {1'b0, hif.flush_m}, {1'b0, c <= 3});
            checkOutput($sformatf("mc%0d.flush_d", c), {1'b0, hif.flush_d}, {1'b0, c > 3});
            advance();
        end

        // Multi-cycle op with a load-use hazard present: no flush_e while busy.
        s = '0; s.mc_start_e = 1; s.memtoreg_e = 1; s.we_e = 1; s.wa_e = 2; s.rs_d = 2;
        runCycle(s, "mc_lu0");
        s.mc_start_e = 0;
        for (int c = 1; c < MC_LAT + 1; c++) runCycle(s, $sformatf("mc_lu%0d", c));

        // Reset in the middle of a multi-cycle op aborts it silently.
        s = '0; s.mc_start_e = 1;
        runCycle(s, "abort0");
        s = '0;
        runCycle(s, "abort1");
        applyStimulus(s);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("abort.mc_busy", {1'b0, hif.mc_busy}, 2'd0);
        checkOutput("abort.mc_done", {1'b0, hif.mc_done}, 2'd0);
        checkOutput("abort.stall_f", {1'b0, hif.stall_f}, 2'd0);
        busy_left = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < MC_LAT + 2; c++) begin
            applyStimulus(s);
            @(negedge clk);
            checkOutput($sformatf("post_abort%0d.mc_done", c), {1'b0, hif.mc_done}, 2'd0);
            checkOutput($sformatf("post_abort%0d.mc_busy", c), {1'b0, hif.mc_busy}, 2'd0);
            advance();
        end

        // Random traffic with a narrow register range to provoke collisions.
        for (int n = 0; n < 600; n++) begin
            s.rs_d       = 5'($urandom_range(0, 7));
            s.rt_d       = 5'($urandom_range(0, 7));
            s.branch_d   = 1'($urandom_range(0, 1));
            s.pc_src_d   = s.branch_d & 1'($urandom_range(0, 1));
            s.rs_e       = 5'($urandom_range(0, 7));
            s.rt_e       = 5'($urandom_range(0, 7));
            s.wa_e       = 5'($urandom_range(0, 7));
            s.we_e       = 1'($urandom_range(0, 1));
            s.memtoreg_e = 1'($urandom_range(0, 1));
            s.mc_start_e = ($urandom_range(0, 15) == 0);
            s.wa_m       = 5'($urandom_range(0, 7));
            s.we_m       = 1'($urandom_range(0, 1));
            s.memtoreg_m = 1'($urandom_range(0, 1));
            s.wa_w       = 5'($urandom_range(0, 7));
            s.we_w       = 1'($urandom_range(0, 1));
            runCycle(s, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter MC_LAT, default 32, meaning the number of cycles a multi-cycle E-stage op (mult/div) occupies E (legal range 2..255).
REQ-002 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports rs_d, rt_d  input  5 each  D-stage source register numbers.
REQ-005 SHALL have ports branch_d, pc_src_d  input  1 each  D-stage branch present / branch-or-jump taken.
REQ-006 SHALL have ports rs_e, rt_e, wa_e  input  5 each, and we_e, memtoreg_e, mc_start_e  input  1 each  E-stage sources, destination, write enable, load flag, multi-cycle op flag.
REQ-007 SHALL have ports wa_m, wa_w  input  5 each, and we_m, memtoreg_m, we_w  input  1 each  M/W destination and write flags.
REQ-008 SHALL have ports stall_f, stall_d, stall_e, flush_d, flush_e, flush_m  output  1 each  pipeline-register hold/clear controls.
REQ-009 SHALL have ports fwd_a_e, fwd_b_e  output  2 each  E operand select: 00 regfile, 01 W result, 10 M result.
REQ-010 SHALL have ports fwd_a_d, fwd_b_d  output  1 each  D branch-compare operand taken from M result.
REQ-011 SHALL have ports mc_busy, mc_done  output  1 each  multi-cycle op in progress / one-cycle completion pulse.

Function
REQ-012 SHALL implement FSM states RUN and MC_WAIT plus an 8-bit down-counter mc_cnt.
REQ-013 In RUN, mc_start_e=1 SHALL move to MC_WAIT on the next edge and load mc_cnt=MC_LAT-2.
REQ-014 In MC_WAIT, mc_cnt SHALL decrement each cycle; at mc_cnt=0 the FSM SHALL return to RUN and mc_done SHALL be 1 for exactly that cycle.
REQ-015 mc_busy SHALL be 1 in RUN with mc_start_e=1 and throughout MC_WAIT; while mc_busy=1: stall_f=stall_d=stall_e=1, flush_m=1, flush_e=0, flush_d=0.
REQ-016 A register match SHALL require the register number to be nonzero; register 0 never causes forwarding or stall.
REQ-017 Load-use stall lu = memtoreg_e & we_e & (wa_e==rs_d | wa_e==rt_d); SHALL assert stall_f, stall_d, flush_e (combinational, same cycle).
REQ-018 Branch stall br = branch_d & ((we_e & wa_e matches rs_d/rt_d) | (memtoreg_m & wa_m matches rs_d/rt_d)); SHALL assert stall_f, stall_d, flush_e.
REQ-019 flush_d SHALL equal pc_src_d & ~stall_d; a taken branch under stall SHALL not flush D.
REQ-020 Priority SHALL be mc_busy > (lu | br) > branch flush; when mc_busy=1, lu/br SHALL not assert flush_e.
REQ-021 fwd_a_e SHALL be 10 if we_m & wa_m==rs_e, else 01 if we_w & wa_w==rs_e, else 00; fwd_b_e likewise with rt_e; M SHALL win over W.
REQ-022 fwd_a_d SHALL be we_m & wa_m==rs_d; fwd_b_d likewise with rt_d.
REQ-023 All outputs except FSM/counter SHALL be combinational from inputs and state; no added latency.

Reset
REQ-024 rst=0 SHALL force state RUN, mc_cnt=0 asynchronously; with all inputs 0 every output SHALL be 0.
REQ-025 rst=0 during MC_WAIT SHALL abort the op with no mc_done pulse; the first clock after release operates from RUN.

Configuration
REQ-026 Macro HAZ_FORWARD_EN SHALL select forwarding; defined: behaviour of REQ-017..REQ-022 as written.
REQ-027 Without HAZ_FORWARD_EN: fwd_* outputs SHALL be constant 0; stall_f/stall_d/flush_e SHALL assert for any D source match against (we_e,wa_e) or (we_m,wa_m), whether or not a branch is in D; MC behaviour unchanged.

Verification
REQ-028 Load-use: memtoreg_e=1, we_e=1, wa_e=5, rs_d=5 -> stall_f=stall_d=flush_e=1 same cycle; wa_e=0 instead -> all 0.
REQ-029 Forward priority: we_m=1, wa_m=7, we_w=1, wa_w=7, rs_e=7 -> fwd_a_e=10; we_m=0 -> fwd_a_e=01.
REQ-030 Multi-cycle, MC_LAT=4: mc_start_e pulse at cycle 0 -> mc_busy 1 on cycles 0-3, mc_done=1 only on cycle 3, flush_m=1 on cycles 0-3, RUN on cycle 4.
REQ-031 Branch: pc_src_d=1 with no hazard -> flush_d=1; same with lu active -> flush_d=0, stall_d=1.
REQ-032 Reset mid-op: rst=0 at cycle 2 of MC_WAIT -> mc_busy=0 immediately, no mc_done pulse after release.
REQ-033 Without HAZ_FORWARD_EN: we_m=1, wa_m=3, rt_d=3 -> stall_d=1, fwd_b_e=00.
